ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Instruction fetch front end that sits directly upstream of the CPU decode/execute stage. It generates sequential fetch addresses to a variable-latency instruction memory, buffers the returned words in a small in-order queue, and presents instruction/PC pairs to the core through a valid/ready handshake. When the core redirects fetch for a taken branch, JAL or JALR, the block flushes its queue and discards stale in-flight responses.

## Interface
- DEPTH, 4: queue entries; also the cap on queue entries plus outstanding requests; power of two, ≥2
- RESET_PC, 32'h0000_0000: first fetch byte address after reset
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts request this cycle
- mem_req_addr  out  32  byte address of request; bits [1:0] always 0
- mem_resp_valid  in  1  one instruction word returned; in order, one per accepted request
- mem_resp_data  in  32  returned instruction word
- out_valid  out  1  queue head valid
- out_ready  in  1  core consumes head this cycle
- out_instr  out  32  head instruction
- out_pc  out  32  head byte address
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and treated as 0

## Operation
- State: fetch_pc, resp_pc, queue (instr+pc per entry, head/tail pointers, count 0..DEPTH), outstanding (0..DEPTH), drop_cnt (0..DEPTH).
- Issue: mem_req_valid = !reset && !redirect_valid && (count + outstanding < DEPTH). Counts are the registered values; a same-cycle pop does not free a credit. mem_req_addr = fetch_pc.
- Accept: mem_req_valid && mem_req_ready -> outstanding+1, fetch_pc+4 (wraps modulo 2^32).
- Response: mem_resp_valid -> outstanding-1. If drop_cnt>0, drop the word and decrement drop_cnt. Otherwise write {mem_resp_data, resp_pc} at tail, count+1, resp_pc+4.
- Pop: out_valid && out_ready && !redirect_valid -> head advances, count-1.
- Pointer wrap: head and tail wrap from DEPTH-1 to 0.
- Overflow: cannot occur by construction.
- Simultaneous push and pop: count unchanged.
- Redirect cycle (priority over all else):
  - queue emptied (count=0, head=tail);
  - out_valid and mem_req_valid forced 0;
  - any response in that cycle is dropped;
  - drop_cnt <= outstanding - mem_resp_valid;
  - fetch_pc and resp_pc <= {redirect_pc[31:2], 2'b00}.
- Responses still outstanding before a redirect never reach out_instr.
- The memory shares the same reset; no responses arrive for requests issued before reset.

## Timing
- Reset values:
  - mem_req_valid=0, mem_req_addr=RESET_PC;
  - out_valid=0, out_instr=0, out_pc=0;
  - fetch_pc=resp_pc=RESET_PC;
  - count=outstanding=drop_cnt=0.
- First cycle after reset deasserts: mem_req_valid=1, addr=RESET_PC.
- Memory latency L≥1: a response arrives no earlier than the cycle after acceptance.
- Response registered into the queue; out_valid rises the cycle after the response (no bypass). Accept at t, response at t+L, out_valid at t+L+1.
- Sustained one instruction per cycle needs DEPTH ≥ L+2 with out_ready held high.
- out_instr and out_pc are held stable while out_valid && !out_ready, except in a redirect cycle.
- After a redirect in cycle r, first request to redirect_pc issues at r+1 if credits allow. Its instruction appears no earlier than r+1+L+1.
- Reset asserted mid-operation clears all state in the same edge.

## Test plan
- Reset, L=1, mem_req_ready=1, out_ready=1 -> requests 0x0,0x4,0x8,...; out_pc 0x0 at cycle 3 after reset release, then one per cycle, instr matches memory.
- out_ready=0, L=2 -> exactly DEPTH(4) requests issued, then mem_req_valid=0; head holds 0x0. Raise out_ready -> in-order drain 0x0..0xC, fetching resumes at 0x10.
- Redirect to 0x103 while 2 requests outstanding -> next request addr 0x100; two stale responses dropped; first out_pc=0x100.
- Redirect in the same cycle as a response and out_valid&&out_ready -> response dropped, no pop counted, out_valid=0 next cycle, drop_cnt = outstanding-1.
- fetch_pc=0xFFFF_FFFC sequential fetch -> next mem_req_addr 0x0000_0000, out_pc wraps identically.
- mem_req_ready toggled pseudo-randomly, L random 1..3, random redirects -> scoreboard: out_pc sequence contiguous between redirects, no duplicates, no stale words.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus bundle: memory request/response channel, core-side
// instruction handshake and the redirect input.
interface ifetch_queue_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // master: the fetch queue itself
  modport master (
    output mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
           redirect_valid, redirect_pc
  );

  // slave: memory + core side
  modport slave (
    input  mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc,
    output mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: sequential fetch to variable-latency memory,
// in-order return queue, redirect flush with drop of stale responses.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  ifetch_queue_if.master bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc_q    [DEPTH];

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  ptr_t        head_q, head_d, tail_q, tail_d;
  cnt_t        count_q, count_d;
  cnt_t        outst_q, outst_d;
  cnt_t        drop_q, drop_d;

  logic        redir, accept, pop, push;
  logic [31:0] redir_pc;
  sum_t        credits_used;

  assign redir        = bus.redirect_valid;
  assign redir_pc     = bus.redirect_pc & 32'hFFFF_FFFC;
  // Credits are taken from registered counts; a pop this cycle frees nothing yet.
  assign credits_used = {1'b0, count_q} + {1'b0, outst_q};

  assign bus.mem_req_valid = !reset && !redir && (credits_used < sum_t'(DEPTH));
  assign bus.mem_req_addr  = fetch_pc_q;
  assign bus.out_valid     = !reset && !redir && (count_q != '0);
  assign bus.out_instr     = instr_q[head_q];
  assign bus.out_pc        = pc_q[head_q];

  assign accept = bus.mem_req_valid && bus.mem_req_ready;
  assign pop    = bus.out_valid && bus.out_ready;
  // Responses owed to a pre-redirect fetch stream are swallowed via drop_q.
  assign push   = bus.mem_resp_valid && (drop_q == '0) && !redir;

  // Next-state: redirect flushes everything and re-arms the drop counter.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (redir) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      outst_d    = outst_q - cnt_t'(bus.mem_resp_valid);
      drop_d     = outst_q - cnt_t'(bus.mem_resp_valid);
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      outst_d = outst_q + cnt_t'(accept) - cnt_t'(bus.mem_resp_valid);
      if (bus.mem_resp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - cnt_t'(1);
        end else begin
          resp_pc_d = resp_pc_q + 32'd4;
          tail_d    = tail_q + ptr_t'(1);
        end
      end
      if (pop) head_d = head_q + ptr_t'(1);
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Queue storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push) begin
      instr_q[tail_q] <= bus.mem_resp_data;
      pc_q[tail_q]    <= resp_pc_q;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: memory BFM with random in-order latency, random
// handshakes/redirects, and a transaction-level model of the expected stream.
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  ifetch_queue_if bus ();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // outstanding memory request: address, fetch epoch it belongs to, due cycle
  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  // instruction the core should see
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        mq[$];
  ent_t        oq[$];
  int          cyc, epoch, last_due, n_chk, n_fail;
  logic [31:0] exp_fetch;
  int          lat_min, lat_max, rdy_pct, ordy_pct;
  bit          redir_now;
  logic [31:0] redir_addr;
  bit          found;

  function automatic logic [31:0] memfn(logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_chk++;
    n_fail++;
    $error("FAIL timeout_%s: condition not reached, expected within bound", tag);
  endtask

  // One clock cycle: drive at negedge, check, then advance the model.
  task automatic step(input bit rst);
    bit rv, ev, eo, acc, pop;
    int d;
    @(negedge clk);
    reset = rst;
    rv = !rst && (mq.size() > 0) && (mq[0].due <= cyc);
    bus.mem_resp_valid = rv;
    bus.mem_resp_data  = rv ? memfn(mq[0].addr) : $urandom;
    bus.mem_req_ready  = ($urandom_range(99) < rdy_pct);
    bus.out_ready      = ($urandom_range(99) < ordy_pct);
    bus.redirect_valid = redir_now && !rst;
    bus.redirect_pc    = redir_addr;
    #1;
    ev = !rst && !redir_now && (oq.size() + mq.size() < DEPTH);
    eo = !rst && !redir_now && (oq.size() > 0);
    chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(ev));
    if (ev) chk("mem_req_addr", bus.mem_req_addr, exp_fetch);
    chk("out_valid", 32'(bus.out_valid), 32'(eo));
    if (eo) begin
      chk("out_pc", bus.out_pc, oq[0].pc);
      chk("out_instr", bus.out_instr, oq[0].instr);
    end
    acc = ev && bus.mem_req_ready;
    pop = eo && bus.out_ready;
    if (rst) begin
      mq.delete();
      oq.delete();
      exp_fetch = RESET_PC;
      last_due  = -1;
      epoch++;
    end else begin
      if (pop) void'(oq.pop_front());
      if (rv) begin
        if (mq[0].epoch == epoch && !redir_now)
          oq.push_back('{mq[0].addr, memfn(mq[0].addr)});
        void'(mq.pop_front());
      end
      if (redir_now) begin
        epoch++;
        oq.delete();
        exp_fetch = {redir_addr[31:2], 2'b00};
      end
      if (acc) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        mq.push_back('{exp_fetch, epoch, d});
        last_due  = d;
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  // Two reset cycles, then check the registered reset values while reset holds.
  task automatic do_reset();
    step(1'b1);
    step(1'b1);
    @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_req_addr", bus.mem_req_addr, RESET_PC);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
  endtask

  task automatic redirect(input logic [31:0] a);
    redir_now  = 1'b1;
    redir_addr = a;
    step(1'b0);
    redir_now  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    redir_now = 1'b0; redir_addr = '0;
    cyc = 0; epoch = 0; last_due = -1; n_chk = 0; n_fail = 0;
    exp_fetch = RESET_PC;

    // streaming, L=1, everything ready
    lat_min = 1; lat_max = 1; rdy_pct = 100; ordy_pct = 100;
    do_reset();
    run(20);

    // core stalled, L=2: fills to DEPTH credits, head holds 0x0, then drains
    lat_min = 2; lat_max = 2; ordy_pct = 0;
    do_reset();
    run(12);
    @(posedge clk);
    #1;
    chk("stall_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("stall_head_pc", bus.out_pc, 32'h0);
    ordy_pct = 100;
    run(16);

    // redirect to 0x103 with two requests in flight
    lat_min = 3; lat_max = 3;
    redirect(32'h0000_0200);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (mq.size() == 2) found = 1'b1;
      else step(1'b0);
    end
    if (!found) timeout("two_outstanding");
    redirect(32'h0000_0103);
    run(16);

    // redirect colliding with a response and a pop
    lat_min = 1; lat_max = 1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (mq.size() > 0 && mq[0].due <= cyc && oq.size() > 0) found = 1'b1;
      else step(1'b0);
    end
    if (!found) timeout("resp_pop_redirect");
    redirect(32'h0000_4000);
    run(12);

    // address wrap at the top of the address space
    redirect(32'hFFFF_FFF0);
    run(20);

    // random handshakes, latencies and redirects
    lat_min = 1; lat_max = 3; rdy_pct = 70; ordy_pct = 75;
    for (int i = 0; i < 1500; i++) begin
      redir_now = ($urandom_range(99) < 4);
      redir_addr = ($urandom_range(7) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31)))
                                             : $urandom;
      step(1'b0);
    end
    redir_now = 1'b0;

    // reset in the middle of traffic
    run(5);
    do_reset();
    run(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
